// File: rtl/controlador_matriz_seta.sv
// Column-scan controller for the 5x7 elevator direction matrix (up, down, idle, blank).
// Define ANIMACAO_EN to scroll the arrow rows once every QUADROS_PASSO frames.
module controlador_matriz_seta #(
   parameter int unsigned CICLOS_COLUNA = 50000,
   parameter int unsigned CICLOS_PAUSA  = 500,
   parameter int unsigned QUADROS_PASSO = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       habilita,
   input  logic [1:0] simbolo,
   output logic [4:0] colunas,
   output logic [6:0] linhas,
   output logic       fim_quadro
);

   localparam int unsigned MAX_CONT = (CICLOS_COLUNA > CICLOS_PAUSA) ? CICLOS_COLUNA : CICLOS_PAUSA;
   localparam int unsigned CNT_W    = (MAX_CONT > 1) ? $clog2(MAX_CONT) : 1;
   localparam logic [CNT_W-1:0] ULT_COL   = CNT_W'(CICLOS_COLUNA - 1);
   localparam logic [CNT_W-1:0] ULT_PAUSA = (CICLOS_PAUSA == 0) ? '0 : CNT_W'(CICLOS_PAUSA - 1);

   typedef enum logic [1:0] {APAGADO, VARRE, PAUSA} estado_t;

   estado_t          estado;
   logic [CNT_W-1:0] cont;
   logic [2:0]       k;
   logic [1:0]       sym_lat;

   logic       fim_col, fim_pausa, avanca, fim_de_quadro;
   logic [2:0] k_prox;
   logic [1:0] sym_prox;
   logic [2:0] off_prox;
   logic [6:0] linhas_prox;
   logic [2:0] offset, offset_quadro;

   // Static active-low pattern, then rotated by the animation offset (arrows only).
   function automatic logic [6:0] padrao(input logic [1:0] sym, input logic [2:0] col,
                                         input logic [2:0] off);
      logic [6:0] p;
      case (sym)
         2'b01:   p = (col == 3'd2) ? 7'b0000000 :
                      (col == 3'd1 || col == 3'd3) ? 7'b1111001 : 7'b1111011;
         2'b10:   p = (col == 3'd2) ? 7'b0000000 :
                      (col == 3'd1 || col == 3'd3) ? 7'b1001111 : 7'b1101111;
         2'b11:   p = 7'b1110111;
         default: p = 7'b1111111;
      endcase
      for (int unsigned i = 0; i < 6; i++) begin
         if (i < 32'(off)) begin
            if (sym == 2'b01)      p = {p[0], p[6:1]};
            else if (sym == 2'b10) p = {p[5:0], p[6]};
         end
      end
      return p;
   endfunction

   always_comb begin
      fim_col       = (estado == VARRE) && (cont == ULT_COL);
      fim_pausa     = (estado == PAUSA) && (cont == ULT_PAUSA);
      avanca        = habilita && (fim_pausa || (fim_col && (CICLOS_PAUSA == 0)));
      fim_de_quadro = (k == 3'd4);
      k_prox        = k + 3'd1;
      sym_prox      = sym_lat;
      off_prox      = offset;
      if (fim_de_quadro) begin
         k_prox   = '0;
         sym_prox = simbolo;
         off_prox = offset_quadro;
      end
      linhas_prox = padrao(sym_prox, k_prox, off_prox);
   end

`ifdef ANIMACAO_EN
   localparam int unsigned QD_W = (QUADROS_PASSO > 1) ? $clog2(QUADROS_PASSO) : 1;
   localparam logic [QD_W-1:0] ULT_QD = QD_W'(QUADROS_PASSO - 1);

   logic [QD_W-1:0] cont_quadro, cont_quadro_prox;

   // Offset for the frame about to start; a new symbol restarts the animation.
   always_comb begin
      offset_quadro    = offset;
      cont_quadro_prox = cont_quadro + 1'b1;
      if (simbolo != sym_lat) begin
         offset_quadro    = '0;
         cont_quadro_prox = '0;
      end else if (cont_quadro == ULT_QD) begin
         cont_quadro_prox = '0;
         offset_quadro    = (offset == 3'd6) ? '0 : offset + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         offset      <= '0;
         cont_quadro <= '0;
      end else if (!habilita || estado == APAGADO) begin
         offset      <= '0;
         cont_quadro <= '0;
      end else if (avanca && fim_de_quadro) begin
         offset      <= offset_quadro;
         cont_quadro <= cont_quadro_prox;
      end
   end
`else
   assign offset        = '0;
   assign offset_quadro = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado     <= APAGADO;
         cont       <= '0;
         k          <= '0;
         sym_lat    <= '0;
         colunas    <= '0;
         linhas     <= '1;
         fim_quadro <= 1'b0;
      end else begin
         fim_quadro <= 1'b0;
         if (!habilita) begin
            estado  <= APAGADO;
            cont    <= '0;
            k       <= '0;
            colunas <= '0;
            linhas  <= '1;
         end else begin
            case (estado)
               APAGADO: begin
                  estado  <= VARRE;
                  cont    <= '0;
                  k       <= '0;
                  sym_lat <= simbolo;
                  colunas <= 5'b00001;
                  linhas  <= padrao(simbolo, 3'd0, 3'd0);
               end
               VARRE, PAUSA: begin
                  if (avanca) begin
                     estado     <= VARRE;
                     cont       <= '0;
                     k          <= k_prox;
                     sym_lat    <= sym_prox;
                     colunas    <= 5'b00001 << k_prox;
                     linhas     <= linhas_prox;
                     fim_quadro <= fim_de_quadro;
                  end else if (fim_col) begin
                     estado  <= PAUSA;
                     cont    <= '0;
                     colunas <= '0;
                     linhas  <= '1;
                  end else begin
                     cont <= cont + 1'b1;
                  end
               end
               default: begin
                  estado  <= APAGADO;
                  colunas <= '0;
                  linhas  <= '1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_controlador_matriz_seta.sv
// Directed bench for controlador_matriz_seta with CICLOS_COLUNA=4, CICLOS_PAUSA=2, QUADROS_PASSO=2.
module tb_controlador_matriz_seta;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       habilita;
   logic [1:0] simbolo;
   logic [4:0] colunas;
   logic [6:0] linhas;
   logic       fim_quadro;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   controlador_matriz_seta #(
      .CICLOS_COLUNA(4),
      .CICLOS_PAUSA (2),
      .QUADROS_PASSO(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .habilita  (habilita),
      .simbolo   (simbolo),
      .colunas   (colunas),
      .linhas    (linhas),
      .fim_quadro(fim_quadro)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hab;
      logic [1:0]  sim;
      int unsigned reps;
      logic [4:0]  col;
      logic [6:0]  lin;
      logic        fim;   // expected on the first repetition only
   } vetor_t;

   vetor_t tab[23];

   task automatic verifica(input string nome, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b t=%0t", nome, got, exp, $time);
      end
   endtask

   task automatic saidas(input string nome, input logic [4:0] c, input logic [6:0] l, input logic f);
      verifica({nome, ".colunas"}, {2'b00, colunas}, {2'b00, c});
      verifica({nome, ".linhas"}, linhas, l);
      verifica({nome, ".fim"}, {6'd0, fim_quadro}, {6'd0, f});
   endtask

   logic [6:0] rot_desce[7];

   initial begin
      tab[0]  = '{1'b1, 2'b10, 4, 5'b00001, 7'b1101111, 1'b0};
      tab[1]  = '{1'b1, 2'b10, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[2]  = '{1'b1, 2'b10, 4, 5'b00010, 7'b1001111, 1'b0};
      tab[3]  = '{1'b1, 2'b10, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[4]  = '{1'b1, 2'b10, 1, 5'b00100, 7'b0000000, 1'b0};
      tab[5]  = '{1'b1, 2'b01, 3, 5'b00100, 7'b0000000, 1'b0};
      tab[6]  = '{1'b1, 2'b01, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[7]  = '{1'b1, 2'b01, 4, 5'b01000, 7'b1001111, 1'b0};
      tab[8]  = '{1'b1, 2'b01, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[9]  = '{1'b1, 2'b01, 4, 5'b10000, 7'b1101111, 1'b0};
      tab[10] = '{1'b1, 2'b01, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[11] = '{1'b1, 2'b01, 4, 5'b00001, 7'b1111011, 1'b1};
      tab[12] = '{1'b1, 2'b01, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[13] = '{1'b1, 2'b01, 4, 5'b00010, 7'b1111001, 1'b0};
      tab[14] = '{1'b1, 2'b01, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[15] = '{1'b1, 2'b01, 4, 5'b00100, 7'b0000000, 1'b0};
      tab[16] = '{1'b1, 2'b01, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[17] = '{1'b1, 2'b01, 2, 5'b01000, 7'b1111001, 1'b0};
      tab[18] = '{1'b0, 2'b01, 1, 5'b00000, 7'b1111111, 1'b0};
      tab[19] = '{1'b0, 2'b11, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[20] = '{1'b1, 2'b11, 4, 5'b00001, 7'b1110111, 1'b0};
      tab[21] = '{1'b1, 2'b11, 2, 5'b00000, 7'b1111111, 1'b0};
      tab[22] = '{1'b1, 2'b11, 4, 5'b00010, 7'b1110111, 1'b0};

      // Down-arrow column 0 rotated toward higher row index by offset 0..6.
      rot_desce[0] = 7'b1101111;
      rot_desce[1] = 7'b1011111;
      rot_desce[2] = 7'b0111111;
      rot_desce[3] = 7'b1111110;
      rot_desce[4] = 7'b1111101;
      rot_desce[5] = 7'b1111011;
      rot_desce[6] = 7'b1110111;

      rst_n    = 1'b0;
      habilita = 1'b0;
      simbolo  = 2'b00;
      @(negedge clk);
      saidas("reset", 5'b00000, 7'b1111111, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         for (int unsigned r = 0; r < tab[i].reps; r++) begin
            habilita = tab[i].hab;
            simbolo  = tab[i].sim;
            @(negedge clk);
            saidas($sformatf("vet%0d.%0d", i, r), tab[i].col, tab[i].lin,
                   (r == 0) ? tab[i].fim : 1'b0);
         end
      end

      // Asynchronous reset in the middle of a PAUSA.
      simbolo = 2'b10;
      @(negedge clk);
      saidas("pausa", 5'b00000, 7'b1111111, 1'b0);
      #2 rst_n = 1'b0;
      #1 saidas("rst_pausa", 5'b00000, 7'b1111111, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      saidas("reinicio", 5'b00001, 7'b1101111, 1'b0);

      // Asynchronous reset while a column is lit must blank before the next edge.
      #2 rst_n = 1'b0;
      #1 saidas("rst_varre", 5'b00000, 7'b1111111, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      saidas("reinicio2", 5'b00001, 7'b1101111, 1'b0);

      // Blank symbol: column strobes but no row lit.
      habilita = 1'b0;
      @(negedge clk);
      habilita = 1'b1;
      simbolo  = 2'b00;
      @(negedge clk);
      saidas("branco", 5'b00001, 7'b1111111, 1'b0);

`ifdef ANIMACAO_EN
      habilita = 1'b0;
      simbolo  = 2'b10;
      @(negedge clk);
      habilita = 1'b1;
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) saidas($sformatf("anim_q%0d", f), 5'b00001, rot_desce[(f / 2) % 7],
                               (f == 0) ? 1'b0 : 1'b1);
         end
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
